// File: rtl/synth_slot_sequencer_if.sv
// Slot-sequencer bus: frame requests from the sample timebase in, and the
// slot index plus strobes out to the envelope, oscillator and mixer stages.
interface synth_slot_sequencer_if #(
    parameter int V_WIDTH = 3,
    parameter int E_WIDTH = 3
);
    logic                       sample_tick;
    logic                       run_en;
    logic                       overrun_clr;
    logic [V_WIDTH+E_WIDTH-1:0] xxxx;
    logic                       n_xxxx_zero;
    logic                       slot_valid;
    logic                       osc_ce;
    logic                       voice_first;
    logic                       frame_done;
    logic                       busy;
    logic                       overrun;
    logic [15:0]                frame_cnt;

    // Timebase / controller side
    modport master (
        output sample_tick, run_en, overrun_clr,
        input  xxxx, n_xxxx_zero, slot_valid, osc_ce, voice_first,
               frame_done, busy, overrun, frame_cnt
    );

    // Sequencer side
    modport slave (
        input  sample_tick, run_en, overrun_clr,
        output xxxx, n_xxxx_zero, slot_valid, osc_ce, voice_first,
               frame_done, busy, overrun, frame_cnt
    );
endinterface

// File: rtl/synth_slot_sequencer.sv
// Frame sequencer: on each accepted sample tick walks every {voice, osc, env}
// slot once, drains the pipeline, then pulses frame_done.
module synth_slot_sequencer #(
    parameter int VOICES       = 8,
    parameter int V_OSC        = 4,
    parameter int O_ENVS       = 2,
    parameter int V_ENVS       = V_OSC * O_ENVS,
    parameter int V_WIDTH      = 3,
    parameter int O_WIDTH      = 2,
    parameter int OE_WIDTH     = 1,
    parameter int E_WIDTH      = O_WIDTH + OE_WIDTH,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                  sCLK_XVXENVS,
    input  logic                  iRST_N,
    synth_slot_sequencer_if.slave bus
);
    localparam int                SW         = V_WIDTH + E_WIDTH;
    localparam logic [SW-1:0]     LAST_SLOT  = SW'(VOICES * V_ENVS - 1);
    localparam logic [3:0]        FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] xxxx_reg, xxxx_next;
    logic          slot_valid_reg, slot_valid_next;
    logic          n_xxxx_zero_reg, n_xxxx_zero_next;
    logic          osc_ce_reg, osc_ce_next;
    logic          voice_first_reg, voice_first_next;
    logic          frame_done_reg, frame_done_next;
    logic          busy_reg, busy_next;
    logic          overrun_reg, overrun_next;
    logic [15:0]   frame_cnt_reg, frame_cnt_next;
    logic [3:0]    flush_cnt_reg, flush_cnt_next;
    logic          start;

    assign start = bus.sample_tick & bus.run_en;

    always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg       <= IDLE;
            xxxx_reg        <= '0;
            slot_valid_reg  <= 1'b0;
            n_xxxx_zero_reg <= 1'b0;
            osc_ce_reg      <= 1'b0;
            voice_first_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
            frame_cnt_reg   <= '0;
            flush_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            xxxx_reg        <= xxxx_next;
            slot_valid_reg  <= slot_valid_next;
            n_xxxx_zero_reg <= n_xxxx_zero_next;
            osc_ce_reg      <= osc_ce_next;
            voice_first_reg <= voice_first_next;
            frame_done_reg  <= frame_done_next;
            busy_reg        <= busy_next;
            overrun_reg     <= overrun_next;
            frame_cnt_reg   <= frame_cnt_next;
            flush_cnt_reg   <= flush_cnt_next;
        end
    end

    // Next values are computed for the cycle being entered so every output is
    // a plain register aligned with the state it describes.
    always_comb begin
        state_next      = state_reg;
        xxxx_next       = xxxx_reg;
        slot_valid_next = 1'b0;
        frame_done_next = 1'b0;
        frame_cnt_next  = frame_cnt_reg;
        flush_cnt_next  = flush_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next      = RUN;
                    xxxx_next       = '0;
                    slot_valid_next = 1'b1;
                end
            end
            RUN: begin
                if (xxxx_reg == LAST_SLOT) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end else begin
                    xxxx_next       = xxxx_reg + SW'(1);
                    slot_valid_next = 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt_reg == 4'd0) begin
                    state_next      = DONE;
                    frame_done_next = 1'b1;
                    frame_cnt_next  = frame_cnt_reg + 16'd1;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 4'd1;
                end
            end
            DONE: begin
                // A tick landing on DONE starts the next frame back-to-back.
                if (start) begin
                    state_next      = RUN;
                    xxxx_next       = '0;
                    slot_valid_next = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next        = (state_next != IDLE);
        n_xxxx_zero_next = slot_valid_next && (xxxx_next == '0);
        osc_ce_next      = slot_valid_next && (xxxx_next[OE_WIDTH-1:0] == '0);
        voice_first_next = slot_valid_next && (xxxx_next[E_WIDTH-1:0] == '0);

        // Set has priority over clear when both arrive together.
        if (bus.sample_tick && (state_reg == RUN || state_reg == FLUSH))
            overrun_next = 1'b1;
        else if (bus.overrun_clr)
            overrun_next = 1'b0;
        else
            overrun_next = overrun_reg;
    end

    assign bus.xxxx        = xxxx_reg;
    assign bus.slot_valid  = slot_valid_reg;
    assign bus.n_xxxx_zero = n_xxxx_zero_reg;
    assign bus.osc_ce      = osc_ce_reg;
    assign bus.voice_first = voice_first_reg;
    assign bus.frame_done  = frame_done_reg;
    assign bus.busy        = busy_reg;
    assign bus.overrun     = overrun_reg;
    assign bus.frame_cnt   = frame_cnt_reg;
endmodule

// File: tb/tb_synth_slot_sequencer.sv
// Directed bench for synth_slot_sequencer: a cycle-indexed vector table plus a
// hand-written mid-frame reset sequence.
module tb_synth_slot_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    synth_slot_sequencer_if #(.V_WIDTH(3), .E_WIDTH(3)) bus ();

    synth_slot_sequencer dut (
        .sCLK_XVXENVS (clk),
        .iRST_N       (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        tick;
        logic        en;
        logic        clr;
        logic [5:0]  x;
        logic        v;
        logic        nz;
        logic        d;
        logic        b;
        logic        o;
        logic [15:0] f;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int c, input bit t, input bit e, input bit r,
                       input int x, input bit v, input bit nz, input bit d,
                       input bit b, input bit o, input int f);
        vec_t w;
        w.cyc = c; w.tick = t; w.en = e; w.clr = r;
        w.x = 6'(x); w.v = v; w.nz = nz; w.d = d; w.b = b; w.o = o; w.f = 16'(f);
        tbl.push_back(w);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".xxxx"},        16'(bus.xxxx), 16'd0);
        chk({tag, ".slot_valid"},  16'(bus.slot_valid), 16'd0);
        chk({tag, ".n_xxxx_zero"}, 16'(bus.n_xxxx_zero), 16'd0);
        chk({tag, ".osc_ce"},      16'(bus.osc_ce), 16'd0);
        chk({tag, ".voice_first"}, 16'(bus.voice_first), 16'd0);
        chk({tag, ".frame_done"},  16'(bus.frame_done), 16'd0);
        chk({tag, ".busy"},        16'(bus.busy), 16'd0);
        chk({tag, ".overrun"},     16'(bus.overrun), 16'd0);
        chk({tag, ".frame_cnt"},   bus.frame_cnt, 16'd0);
    endtask

    initial begin
        int         ri;
        int         osc_cnt;
        int         vf_cnt;
        logic       prev_v;
        logic [5:0] prev_x;
        logic [5:0] exp_x;

        checks = 0; errors = 0; cyc = 0;
        bus.sample_tick = 1'b0;
        bus.run_en      = 1'b1;
        bus.overrun_clr = 1'b0;
        rst_n = 1'b0;

        //   cyc tk en cl   x  v nz d  b  o  f
        add(  0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        add( 10, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        add( 11, 0, 1, 0,  0, 1, 1, 0, 1, 0, 0);
        add( 12, 0, 1, 0,  1, 1, 0, 0, 1, 0, 0);
        add( 40, 1, 1, 0, 29, 1, 0, 0, 1, 0, 0);
        add( 41, 0, 1, 0, 30, 1, 0, 0, 1, 1, 0);
        add( 60, 0, 1, 1, 49, 1, 0, 0, 1, 1, 0);
        add( 61, 0, 1, 0, 50, 1, 0, 0, 1, 0, 0);
        add( 74, 0, 1, 0, 63, 1, 0, 0, 1, 0, 0);
        add( 75, 0, 1, 0, 63, 0, 0, 0, 1, 0, 0);
        add( 78, 0, 1, 0, 63, 0, 0, 0, 1, 0, 0);
        add( 79, 1, 1, 0, 63, 0, 0, 1, 1, 0, 1);
        add( 80, 0, 1, 0,  0, 1, 1, 0, 1, 0, 1);
        add(100, 1, 1, 1, 20, 1, 0, 0, 1, 0, 1);
        add(101, 0, 1, 0, 21, 1, 0, 0, 1, 1, 1);
        add(110, 0, 1, 1, 30, 1, 0, 0, 1, 1, 1);
        add(111, 0, 1, 0, 31, 1, 0, 0, 1, 0, 1);
        add(143, 0, 1, 0, 63, 1, 0, 0, 1, 0, 1);
        add(146, 1, 1, 0, 63, 0, 0, 0, 1, 0, 1);
        add(147, 0, 1, 0, 63, 0, 0, 0, 1, 1, 1);
        add(148, 0, 1, 0, 63, 0, 0, 1, 1, 1, 2);
        add(149, 0, 1, 0, 63, 0, 0, 0, 0, 1, 2);
        add(150, 0, 1, 1, 63, 0, 0, 0, 0, 1, 2);
        add(151, 0, 1, 0, 63, 0, 0, 0, 0, 0, 2);
        add(160, 1, 0, 0, 63, 0, 0, 0, 0, 0, 2);
        add(161, 0, 0, 0, 63, 0, 0, 0, 0, 0, 2);
        add(170, 1, 1, 0, 63, 0, 0, 0, 0, 0, 2);
        add(171, 0, 1, 0,  0, 1, 1, 0, 1, 0, 2);
        add(191, 0, 0, 0, 20, 1, 0, 0, 1, 0, 2);
        add(234, 0, 0, 0, 63, 1, 0, 0, 1, 0, 2);
        add(239, 1, 0, 0, 63, 0, 0, 1, 1, 0, 3);
        add(240, 0, 0, 0, 63, 0, 0, 0, 0, 0, 3);
        add(245, 1, 0, 0, 63, 0, 0, 0, 0, 0, 3);
        add(246, 0, 0, 0, 63, 0, 0, 0, 0, 0, 3);

        repeat (3) step();
        rst_n = 1'b1;
        cyc = 0;

        ri = 0; osc_cnt = 0; vf_cnt = 0; prev_v = 1'b0; prev_x = '0;
        for (int c = 0; c <= 250; c++) begin
            // Strobe decode and slot continuity on every cycle
            if (bus.slot_valid) begin
                exp_x = bus.xxxx;
                chk("osc_ce_decode", 16'(bus.osc_ce), 16'(exp_x[0] == 1'b0));
                chk("voice_first_decode", 16'(bus.voice_first), 16'(exp_x[2:0] == 3'd0));
                chk("n_xxxx_zero_decode", 16'(bus.n_xxxx_zero), 16'(exp_x == 6'd0));
                if (prev_v) chk("xxxx_step", 16'(bus.xxxx), 16'(prev_x + 6'd1));
            end else begin
                chk("strobes_idle", {13'd0, bus.osc_ce, bus.voice_first, bus.n_xxxx_zero}, 16'd0);
            end
            if (c >= 11 && c <= 74) begin
                osc_cnt += int'(bus.osc_ce);
                vf_cnt  += int'(bus.voice_first);
            end
            prev_v = bus.slot_valid;
            prev_x = bus.xxxx;

            bus.sample_tick = 1'b0;
            bus.overrun_clr = 1'b0;
            if (ri < tbl.size() && tbl[ri].cyc == c) begin
                chk("xxxx",        16'(bus.xxxx),        16'(tbl[ri].x));
                chk("slot_valid",  16'(bus.slot_valid),  16'(tbl[ri].v));
                chk("n_xxxx_zero", 16'(bus.n_xxxx_zero), 16'(tbl[ri].nz));
                chk("frame_done",  16'(bus.frame_done),  16'(tbl[ri].d));
                chk("busy",        16'(bus.busy),        16'(tbl[ri].b));
                chk("overrun",     16'(bus.overrun),     16'(tbl[ri].o));
                chk("frame_cnt",   bus.frame_cnt,        tbl[ri].f);
                $display("vec cyc=%0d tick=%0b en=%0b clr=%0b xxxx=%0d valid=%0b done=%0b busy=%0b ovr=%0b fcnt=%0d",
                         c, tbl[ri].tick, tbl[ri].en, tbl[ri].clr, bus.xxxx, bus.slot_valid,
                         bus.frame_done, bus.busy, bus.overrun, bus.frame_cnt);
                bus.sample_tick = tbl[ri].tick;
                bus.run_en      = tbl[ri].en;
                bus.overrun_clr = tbl[ri].clr;
                ri++;
            end
            step();
        end
        bus.sample_tick = 1'b0;
        bus.overrun_clr = 1'b0;
        chk("table_consumed", 16'(ri), 16'(tbl.size()));
        chk("osc_ce_pulses", 16'(osc_cnt), 16'd32);
        chk("voice_first_pulses", 16'(vf_cnt), 16'd8);
        $display("strobes osc_ce=%0d voice_first=%0d", osc_cnt, vf_cnt);

        // Mid-frame asynchronous reset, then a clean restart
        bus.run_en = 1'b1;
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        repeat (30) step();
        chk("pre_reset_xxxx", 16'(bus.xxxx), 16'd30);
        chk("pre_reset_fcnt", bus.frame_cnt, 16'd3);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        $display("reset mid-frame xxxx=%0d busy=%0b fcnt=%0d", bus.xxxx, bus.busy, bus.frame_cnt);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_all_zero("post_release");
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        chk("restart_xxxx", 16'(bus.xxxx), 16'd0);
        chk("restart_valid", 16'(bus.slot_valid), 16'd1);
        chk("restart_nzero", 16'(bus.n_xxxx_zero), 16'd1);
        repeat (63) step();
        chk("restart_last", 16'(bus.xxxx), 16'd63);
        repeat (4) step();
        chk("restart_flush_done", 16'(bus.frame_done), 16'd0);
        step();
        chk("restart_done", 16'(bus.frame_done), 16'd1);
        chk("restart_fcnt", bus.frame_cnt, 16'd1);
        $display("restart frame_done=%0b fcnt=%0d", bus.frame_done, bus.frame_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
